// File: rtl/collector_pkg.sv
// ---------------------------------------------------------------------------
// collector_pkg
// Shared definitions for the collector's serial front ends.
//   rx_state_e : receive framer states
//   BYTE_W     : width of one serial character / FIFO entry
//   BAUD_W     : width of the bit-period field, matching the control-unit
//                registers that program it
// ---------------------------------------------------------------------------
package collector_pkg;

    localparam int BYTE_W = 8;
    localparam int BAUD_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HI
    } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered read data. Shared by the receive and
// transmit paths of the collector.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write strobe and data
//   pop        : read strobe; rdata is loaded on the following edge
//   rdata      : last popped word (registered)
//   full/empty : occupancy flags
// A push while full is accepted only if a pop happens in the same cycle;
// a pop while empty is ignored.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra bit: equal indices with differing MSBs
    // means the write pointer has lapped the read pointer.
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            rdata <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr  <= rptr + 1'b1;
                rdata <= mem[rptr[AW-1:0]];
            end
        end
    end

    // When full with a simultaneous pop, the write lands on the slot being
    // read; the read above still sees the old word.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// 8N1 serial receiver with a byte FIFO, one per collector input port.
//   i_clk, i_rst : sampling clock, asynchronous active-low reset
//   i_rx         : asynchronous serial line, idles high
//   i_baud       : bit period minus one in i_clk cycles (0 behaves as 1)
//   i_read       : pop strobe from the collector
//   o_ready      : FIFO holds at least one byte
//   o_used       : one-cycle pulse, o_D carries a popped byte
//   o_D          : popped byte on the shared bus, high-Z when o_used=0
//   o_ferr       : one-cycle pulse on a framing error
//   o_overrun    : one-cycle pulse when a received byte is dropped
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import collector_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx,
    input  logic [BAUD_W-1:0] i_baud,
    input  logic              i_read,
    output logic              o_ready,
    output logic              o_used,
    output logic [BYTE_W-1:0] o_D,
    output logic              o_ferr,
    output logic              o_overrun
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   rxs_prev;
    logic                   start_edge;

    rx_state_e              state;
    rx_state_e              state_next;
    logic [BAUD_W-1:0]      period;
    logic [BAUD_W-1:0]      cnt;
    logic [2:0]             bit_idx;
    logic [BYTE_W-1:0]      shreg;
    logic                   mid_pt;
    logic                   end_pt;

    logic                   sample;
    logic                   push;
    logic                   ferr_set;

    logic [BYTE_W-1:0]      rdata;
    logic                   full;
    logic                   empty;
    logic                   pop_ok;
    logic                   used_q;
    logic                   ferr_q;
    logic                   overrun_q;

    // Line synchronizer; stages reset to the idle level so reset release
    // never looks like a start bit.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sync_q   <= '1;
            rxs_prev <= 1'b1;
        end else begin
            sync_q[0] <= i_rx;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            rxs_prev <= rxs;
        end
    end

    assign rxs        = sync_q[SYNC_STAGES-1];
    assign start_edge = rxs_prev && !rxs;
    assign mid_pt     = (cnt == (period >> 1));
    assign end_pt     = (cnt == period);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The stop bit is judged at its midpoint so the framer is back in IDLE
    // before the next start bit can arrive.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_edge) state_next = START;
            START:   if (mid_pt && rxs) state_next = IDLE;
                     else if (end_pt) state_next = DATA;
            DATA:    if (end_pt && bit_idx == 3'd7) state_next = STOP;
            STOP:    if (mid_pt) state_next = rxs ? IDLE : WAIT_HI;
            WAIT_HI: if (rxs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sample   = 1'b0;
        push     = 1'b0;
        ferr_set = 1'b0;
        case (state)
            DATA: sample = mid_pt;
            STOP: begin
                push     = mid_pt && rxs;
                ferr_set = mid_pt && !rxs;
            end
            default: ;
        endcase
    end

    // Bit timing. The period is captured at start detection so a baud
    // change never disturbs a frame already in flight.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            period  <= BAUD_W'(1);
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state == IDLE) begin
                cnt     <= '0;
                bit_idx <= '0;
                if (start_edge) begin
                    period <= (i_baud == '0) ? BAUD_W'(1) : i_baud;
                end
            end else begin
                cnt <= end_pt ? '0 : cnt + 1'b1;
                if (state == DATA && end_pt) begin
                    bit_idx <= bit_idx + 1'b1;
                end
            end
            if (sample) begin
                shreg <= {rxs, shreg[BYTE_W-1:1]};
            end
        end
    end

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst),
        .push  (push),
        .wdata (shreg),
        .pop   (i_read),
        .rdata (rdata),
        .full  (full),
        .empty (empty)
    );

    assign pop_ok = i_read && !empty;

    // A push into a full FIFO survives only when a pop frees a slot in
    // the same cycle; otherwise the byte is lost and flagged.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            used_q    <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            used_q    <= pop_ok;
            ferr_q    <= ferr_set;
            overrun_q <= push && full && !pop_ok;
        end
    end

    assign o_ready   = !empty;
    assign o_used    = used_q;
    assign o_D       = used_q ? rdata : 'z;
    assign o_ferr    = ferr_q;
    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Bench for uart_rx_fifo. A queue model tracks the FIFO contents; each sent
// frame schedules its push (or framing error) at the cycle implied by the
// line timing: 2 sync stages, 1 edge to enter START, one start bit and eight
// data bits of P+1 cycles, then the stop-bit midpoint. The bus is pulled up,
// so an undriven o_D reads as 8'hFF.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic        i_clk  = 1'b0;
    logic        i_rst  = 1'b0;
    logic        i_rx   = 1'b1;
    logic [15:0] i_baud = 16'd3;
    logic        i_read = 1'b0;
    logic        o_ready;
    logic        o_used;
    logic        o_ferr;
    logic        o_overrun;
    wire  [7:0]  bus_d;

    pullup (bus_d);

    uart_rx_fifo #(
        .DEPTH       (DEPTH),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_rx      (i_rx),
        .i_baud    (i_baud),
        .i_read    (i_read),
        .o_ready   (o_ready),
        .o_used    (o_used),
        .o_D       (bus_d),
        .o_ferr    (o_ferr),
        .o_overrun (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int         at;
        logic [7:0] data;
        bit         good;
    } ev_t;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         frame_start = 0;
    int         frame_count = 0;
    int         ovr_seen = 0;
    int         ferr_seen = 0;
    ev_t        sched[$];
    logic [7:0] model_q[$];
    bit         exp_used = 1'b0;
    bit         exp_ferr = 1'b0;
    bit         exp_ovr  = 1'b0;
    logic [7:0] exp_data = 8'h00;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h, required %0h at cycle %0d",
                     name, actual, expected, cyc);
        end
    endtask

    // Model step: reset throws away the queue and any frame in flight.
    always @(negedge i_rst) begin
        model_q.delete();
        sched.delete();
        exp_used = 1'b0;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
    end

    always @(posedge i_clk) begin : model
        int         pre;
        bit         pop_ok;
        bit         push_rq;
        bit         push_ok;
        bit         ferr_rq;
        logic [7:0] d;
        cyc++;
        if (i_rst) begin
            push_rq = 1'b0;
            ferr_rq = 1'b0;
            d       = 8'h00;
            while (sched.size() > 0 && sched[0].at == cyc) begin
                if (sched[0].good) begin
                    push_rq = 1'b1;
                    d       = sched[0].data;
                end else begin
                    ferr_rq = 1'b1;
                end
                void'(sched.pop_front());
            end
            pre     = model_q.size();
            pop_ok  = i_read && (pre > 0);
            push_ok = push_rq && ((pre < DEPTH) || pop_ok);
            exp_used = pop_ok;
            if (pop_ok) begin
                exp_data = model_q.pop_front();
            end
            if (push_ok) begin
                model_q.push_back(d);
            end
            exp_ovr  = push_rq && !push_ok;
            exp_ferr = ferr_rq;
        end
    end

    always @(posedge i_clk) begin
        #2;
        if (i_rst) begin
            check_output("ready", o_ready, model_q.size() != 0);
            check_output("used", o_used, exp_used);
            check_output("bus", bus_d, exp_used ? exp_data : 8'hFF);
            check_output("ferr", o_ferr, exp_ferr);
            check_output("overrun", o_overrun, exp_ovr);
            if (o_overrun) ovr_seen++;
            if (o_ferr) ferr_seen++;
        end
    end

    // Drives one 8N1 frame starting at the next falling clock edge. The
    // stop level is left on the line when the task returns.
    task automatic send_frame(input logic [7:0] d, input bit stop_bit,
                              input int switch_bit, input logic [15:0] new_baud);
        int p;
        p = (i_baud == 16'd0) ? 1 : int'(i_baud);
        @(negedge i_clk);
        i_rx        = 1'b0;
        frame_start = cyc + 1;
        sched.push_back('{at: frame_start + 9 * (p + 1) + 3 + (p >> 1),
                          data: d, good: stop_bit});
        frame_count++;
        repeat (p + 1) @(negedge i_clk);
        for (int b = 0; b < 8; b++) begin
            if (b == switch_bit) i_baud = new_baud;
            i_rx = d[b];
            repeat (p + 1) @(negedge i_clk);
        end
        i_rx = stop_bit;
        repeat (p + 1) @(negedge i_clk);
    endtask

    task automatic read_byte(input string name, input bit want_used,
                             input logic [7:0] want_d);
        @(negedge i_clk);
        i_read = 1'b1;
        @(negedge i_clk);
        i_read = 1'b0;
        check_output({name, "_used"}, o_used, want_used);
        check_output({name, "_data"}, bus_d, want_used ? want_d : 8'hFF);
    endtask

    task automatic read_burst(input string name, input int n,
                              input logic [7:0] first, input logic [7:0] last_val);
        @(negedge i_clk);
        i_read = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            if (i == n - 1) i_read = 1'b0;
            check_output(name, bus_d, (i == n - 1) ? last_val : first + 8'(i));
        end
    endtask

    task automatic apply_stimulus();
        int fc0;
        int rise;

        // Reset values while held in reset.
        #1;
        check_output("rst_ready", o_ready, 1'b0);
        check_output("rst_used", o_used, 1'b0);
        check_output("rst_bus", bus_d, 8'hFF);
        check_output("rst_ferr", o_ferr, 1'b0);
        check_output("rst_overrun", o_overrun, 1'b0);
        repeat (3) @(negedge i_clk);
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);

        $display("[TB] single byte 0x55 at 4 cycles/bit");
        i_baud = 16'd3;
        send_frame(8'h55, 1'b1, -1, 16'd0);
        rise = -1;
        for (int i = 0; i < 100 && rise < 0; i++) begin
            if (o_ready) rise = cyc;
            else @(negedge i_clk);
        end
        check_output("ready_latency", rise - frame_start, 40);
        read_byte("single", 1'b1, 8'h55);
        check_output("single_ready_after", o_ready, 1'b0);
        @(negedge i_clk);
        check_output("single_bus_release", bus_d, 8'hFF);

        $display("[TB] glitch and framing error");
        i_baud    = 16'd7;
        ferr_seen = 0;
        @(negedge i_clk);
        i_rx = 1'b0;
        @(negedge i_clk);
        i_rx = 1'b1;
        repeat (30) @(negedge i_clk);
        check_output("glitch_ready", o_ready, 1'b0);
        check_output("glitch_ferr", ferr_seen, 0);
        send_frame(8'hA3, 1'b0, -1, 16'd0);
        repeat (60) @(negedge i_clk);
        i_rx = 1'b1;
        repeat (20) @(negedge i_clk);
        check_output("ferr_count", ferr_seen, 1);
        check_output("ferr_ready", o_ready, 1'b0);

        $display("[TB] overrun with 17 bytes");
        i_baud   = 16'd1;
        ovr_seen = 0;
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1, -1, 16'd0);
        end
        repeat (6) @(negedge i_clk);
        check_output("overrun_count", ovr_seen, 1);
        read_burst("overrun_burst", 16, 8'h00, 8'h0F);
        read_byte("overrun_extra", 1'b0, 8'h00);
        check_output("overrun_drained", o_ready, 1'b0);

        $display("[TB] full FIFO with simultaneous pop, baud field 0");
        i_baud   = 16'd0;
        ovr_seen = 0;
        for (int i = 0; i < 16; i++) begin
            send_frame(8'h80 + 8'(i), 1'b1, -1, 16'd0);
        end
        fc0 = frame_count;
        fork
            send_frame(8'h77, 1'b1, -1, 16'd0);
            begin
                wait (frame_count != fc0);
                for (int i = 0; i < 100 && cyc < frame_start + 20; i++) begin
                    @(negedge i_clk);
                end
                i_read = 1'b1;
                @(negedge i_clk);
                i_read = 1'b0;
                check_output("fullpop_used", o_used, 1'b1);
                check_output("fullpop_data", bus_d, 8'h80);
            end
        join
        repeat (4) @(negedge i_clk);
        check_output("fullpop_overrun", ovr_seen, 0);
        read_burst("fullpop_burst", 16, 8'h81, 8'h77);
        read_byte("fullpop_extra", 1'b0, 8'h00);

        $display("[TB] reset during DATA bit 4");
        i_baud = 16'd3;
        for (int i = 0; i < 3; i++) begin
            send_frame(8'h10 + 8'(i), 1'b1, -1, 16'd0);
        end
        repeat (5) @(negedge i_clk);
        check_output("prerst_ready", o_ready, 1'b1);
        fc0 = frame_count;
        fork
            send_frame(8'h99, 1'b1, -1, 16'd0);
            begin
                wait (frame_count != fc0);
                for (int i = 0; i < 100 && cyc < frame_start + 23; i++) begin
                    @(negedge i_clk);
                end
                i_rst = 1'b0;
                #1;
                check_output("midrst_ready", o_ready, 1'b0);
                check_output("midrst_used", o_used, 1'b0);
                check_output("midrst_bus", bus_d, 8'hFF);
                check_output("midrst_ferr", o_ferr, 1'b0);
                check_output("midrst_overrun", o_overrun, 1'b0);
            end
        join
        @(negedge i_clk);
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        send_frame(8'hC6, 1'b1, -1, 16'd0);
        repeat (5) @(negedge i_clk);
        read_byte("postrst", 1'b1, 8'hC6);
        read_byte("postrst_extra", 1'b0, 8'h00);

        $display("[TB] baud change mid-frame");
        i_baud = 16'd3;
        send_frame(8'h3C, 1'b1, 3, 16'd9);
        send_frame(8'hE1, 1'b1, -1, 16'd0);
        repeat (5) @(negedge i_clk);
        read_byte("baud_first", 1'b1, 8'h3C);
        read_byte("baud_second", 1'b1, 8'hE1);
        read_byte("baud_extra", 1'b0, 8'h00);
        repeat (5) @(negedge i_clk);
    endtask

    initial begin
        apply_stimulus();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
